spi_master_xfer: RTL

- Parametrised full-duplex serial master; successor to the fixed 6-bit Moore-FSM serial transmitter.
- Accepts a DATA_W-bit word over a valid/ready handshake, frames it with cs_n, and shifts it out on mosi under a divided sclk.
- Samples miso on the same transfer and returns the received word with a one-cycle done pulse.
- Sits between a local controller and an off-chip SPI slave. Supports all four CPOL/CPHA modes, either bit order, and a programmable clock divider.

---
 rtl/spi_master_xfer.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/spi_master_xfer.sv
// -----------------------------------------------------------------------------
// spi_master_xfer
//
// Full-duplex SPI master for one word per transfer. A word accepted over the
// tx_valid/tx_ready handshake is framed by cs_n and shifted out on mosi under
// a divided sclk. miso is captured during the same transfer, and the received
// word is presented on rx_data together with a one-cycle done pulse.
//
// Transfer timeline, with D = CLK_DIV and W = DATA_W, counted from the
// accept cycle (cycle 0):
//   SETUP  cycles 1 .. D              cs_n low, sclk idle
//   SHIFT  cycles D+1 .. D+2WD        2W sclk edges, one every D cycles
//   HOLD   cycles 2WD+D+1 .. 2WD+2D   cs_n still low, mosi holds last bit
//   DONE   cycle 2WD+2D+1             cs_n high, done pulse, rx_data updated
//   IDLE   cycle 2WD+2D+2 onward      tx_ready high again
//
// Parameters:
//   DATA_W    bits per transfer (>= 2)
//   CLK_DIV   clk cycles per sclk half-period (>= 1)
//   CPOL      sclk idle level
//   CPHA      0: sample on leading edge, shift on trailing edge
//             1: shift on leading edge, sample on trailing edge
//   MSB_FIRST 1: bit DATA_W-1 first, 0: bit 0 first
//
// Ports:
//   clk       system clock; all logic on its rising edge
//   rst       synchronous active-high reset
//   tx_data   word to send; sampled only in the accept cycle
//   tx_valid  request a transfer
//   tx_ready  high only in IDLE and while rst is low (combinational)
//   rx_data   received word; updated in the done cycle, held otherwise
//   done      one-cycle pulse at the end of a transfer
//   busy      high in every state except IDLE
//   sclk      serial clock
//   cs_n      chip select, active low
//   mosi      serial data out
//   miso      serial data in
// -----------------------------------------------------------------------------
module spi_master_xfer #(
  parameter int DATA_W    = 8,
  parameter int CLK_DIV   = 2,
  parameter bit CPOL      = 1'b0,
  parameter bit CPHA      = 1'b0,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              done,
  output logic              busy,
  output logic              sclk,
  output logic              cs_n,
  output logic              mosi,
  input  logic              miso
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE    = DIV_W'(1);
  localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0] BIT_ONE    = BIT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_DONE
  } state_t;

  state_t              state_q;
  logic [DIV_W-1:0]    div_q;      // cycles left until the next sclk event
  logic [BIT_W-1:0]    bit_q;      // index of the bit currently on the wire
  logic                lead_q;     // last sclk edge issued was a leading edge
  logic                last_q;     // all 2W edges have been issued
  logic [DATA_W-1:0]   tx_sh_q;    // bits still to be driven onto mosi
  logic [DATA_W-1:0]   rx_sh_q;    // bits captured from miso so far
  logic [DATA_W-1:0]   rx_data_q;
  logic                sclk_q;
  logic                cs_n_q;
  logic                mosi_q;
  logic                done_q;
  logic                busy_q;

  // Bit that leaves the shift register next.
  function automatic logic first_bit(input logic [DATA_W-1:0] v);
    if (MSB_FIRST) begin
      return v[DATA_W-1];
    end
    return v[0];
  endfunction

  // Shift register after the outgoing bit has been consumed.
  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] v);
    if (MSB_FIRST) begin
      return {v[DATA_W-2:0], 1'b0};
    end
    return {1'b0, v[DATA_W-1:1]};
  endfunction

  // Shift a received bit in so that the first bit ends up in the MSB
  // (MSB_FIRST) or in the LSB (LSB first) once all W bits are in.
  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] v,
                                                  input logic b);
    if (MSB_FIRST) begin
      return {v[DATA_W-2:0], b};
    end
    return {b, v[DATA_W-1:1]};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      bit_q     <= '0;
      lead_q    <= 1'b0;
      last_q    <= 1'b0;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      sclk_q    <= CPOL;
      cs_n_q    <= 1'b1;
      mosi_q    <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // tx_ready is exactly "IDLE and not in reset", so tx_valid alone
          // completes the handshake here.
          if (tx_valid) begin
            state_q <= S_SETUP;
            busy_q  <= 1'b1;
            cs_n_q  <= 1'b0;
            div_q   <= DIV_RELOAD;
            bit_q   <= '0;
            lead_q  <= 1'b0;
            last_q  <= 1'b0;
            rx_sh_q <= '0;
            if (!CPHA) begin
              // First bit must be stable before the first (sampling) edge.
              mosi_q  <= first_bit(tx_data);
              tx_sh_q <= shift_out(tx_data);
            end else begin
              // First bit is launched by the first leading edge.
              mosi_q  <= 1'b0;
              tx_sh_q <= tx_data;
            end
          end
        end

        S_SETUP: begin
          if (div_q == '0) begin
            // Leading edge k=0.
            state_q <= S_SHIFT;
            div_q   <= DIV_RELOAD;
            sclk_q  <= ~sclk_q;
            lead_q  <= 1'b1;
            if (!CPHA) begin
              rx_sh_q <= shift_in(rx_sh_q, miso);
            end else begin
              mosi_q  <= first_bit(tx_sh_q);
              tx_sh_q <= shift_out(tx_sh_q);
            end
          end else begin
            div_q <= div_q - DIV_ONE;
          end
        end

        S_SHIFT: begin
          if (div_q != '0) begin
            div_q <= div_q - DIV_ONE;
          end else if (last_q) begin
            // One half-period has elapsed after the final edge.
            state_q <= S_HOLD;
            div_q   <= DIV_RELOAD;
          end else begin
            div_q  <= DIV_RELOAD;
            sclk_q <= ~sclk_q;
            if (lead_q) begin
              // Trailing edge closes bit bit_q.
              lead_q <= 1'b0;
              if (CPHA) begin
                rx_sh_q <= shift_in(rx_sh_q, miso);
              end
              if (bit_q == LAST_BIT) begin
                // Final trailing edge: no further mosi update.
                last_q <= 1'b1;
              end else begin
                bit_q <= bit_q + BIT_ONE;
                if (!CPHA) begin
                  mosi_q  <= first_bit(tx_sh_q);
                  tx_sh_q <= shift_out(tx_sh_q);
                end
              end
            end else begin
              // Leading edge opens bit bit_q.
              lead_q <= 1'b1;
              if (!CPHA) begin
                rx_sh_q <= shift_in(rx_sh_q, miso);
              end else begin
                mosi_q  <= first_bit(tx_sh_q);
                tx_sh_q <= shift_out(tx_sh_q);
              end
            end
          end
        end

        S_HOLD: begin
          if (div_q != '0) begin
            div_q <= div_q - DIV_ONE;
          end else begin
            state_q   <= S_DONE;
            cs_n_q    <= 1'b1;
            mosi_q    <= 1'b0;
            done_q    <= 1'b1;
            rx_data_q <= rx_sh_q;
          end
        end

        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          cs_n_q  <= 1'b1;
          sclk_q  <= CPOL;
          mosi_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx_ready = (state_q == S_IDLE) && !rst;
  assign rx_data  = rx_data_q;
  assign done     = done_q;
  assign busy     = busy_q;
  assign sclk     = sclk_q;
  assign cs_n     = cs_n_q;
  assign mosi     = mosi_q;

endmodule
